// File: rtl/div_sched_ctrl.sv
// -----------------------------------------------------------------------------
// div_sched_ctrl
//   Scheduler for the power-of-two clock-division datapath. Produces a
//   clock-enable pulse on the last cycle of each 2^cur_sq-cycle period and a
//   50% divided phase. New exponents arrive over a valid/ready handshake and
//   take effect only on a period boundary, so a running period is never cut
//   short.
//
// Optional feature (macro DIV_SCHED_PERIOD_CNT_EN):
//   Adds the period_cnt output, a saturating count of clk_en pulses that is
//   cleared whenever cur_sq changes.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous reset, active-high
//   enable     in   level: 1 = run the divider, 0 = idle
//   cfg_valid  in   new exponent offered
//   cfg_sq     in   requested divide exponent (SQ_W bits)
//   cfg_ready  out  scheduler can accept cfg_sq (low only while a change is pending)
//   cfg_done   out  one-cycle pulse: new exponent now in effect
//   cfg_err    out  one-cycle pulse: request rejected (cfg_sq > MAX_SQ)
//   cur_sq     out  exponent currently in effect (SQ_W bits)
//   clk_en     out  one-cycle pulse on the last cycle of each period
//   div_phase  out  divided square wave (low first half, high second half)
//   busy       out  scheduler not idle
//   period_cnt out  16-bit saturating period count (optional feature only)
// -----------------------------------------------------------------------------
module div_sched_ctrl #(
  parameter int MAX_SQ = 8,
  parameter int SQ_W   = 4,
  parameter int RST_SQ = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            cfg_valid,
  input  logic [SQ_W-1:0] cfg_sq,
  output logic            cfg_ready,
  output logic            cfg_done,
  output logic            cfg_err,
  output logic [SQ_W-1:0] cur_sq,
  output logic            clk_en,
  output logic            div_phase,
`ifdef DIV_SCHED_PERIOD_CNT_EN
  output logic [15:0]     period_cnt,
`endif
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [MAX_SQ:0] ONE_W = (MAX_SQ + 1)'(1);

  state_t            state_q, state_d;
  logic [MAX_SQ-1:0] cnt_q, cnt_d;
  logic [SQ_W-1:0]   cur_sq_q, cur_sq_d;
  logic [SQ_W-1:0]   pend_sq_q, pend_sq_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              running;
  logic              term;
  logic              xfer;
  logic              sq_bad;
  logic [MAX_SQ:0]   period_len;
  logic [MAX_SQ:0]   last_idx;
  logic [MAX_SQ:0]   half_len;
  logic [MAX_SQ-1:0] cnt_next;

  // Period length is one bit wider than the counter so 2^MAX_SQ is representable.
  assign period_len = ONE_W << cur_sq_q;
  assign last_idx   = period_len - ONE_W;
  assign half_len   = period_len >> 1;

  assign running  = (state_q != IDLE);
  assign term     = (cnt_q == last_idx[MAX_SQ-1:0]);
  assign cnt_next = term ? '0 : cnt_q + MAX_SQ'(1);
  assign xfer     = cfg_valid & cfg_ready;
  assign sq_bad   = (cfg_sq > SQ_W'(MAX_SQ));

  assign cfg_ready = (state_q != PEND);
  assign busy      = running;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign cur_sq    = cur_sq_q;
  assign clk_en    = running & term;
  // The half-period bit is zero when cur_sq=0, which forces the phase low.
  assign div_phase = running & (|(cnt_q & half_len[MAX_SQ-1:0]));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sq_d  = cur_sq_q;
    pend_sq_d = pend_sq_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (sq_bad) begin
            err_d = 1'b1;
          end else begin
            cur_sq_d = cfg_sq;
            done_d   = 1'b1;
          end
        end
        if (enable) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end

      RUN: begin
        if (!enable) begin
          // Partial period is abandoned; a coincident request needs no
          // boundary to wait for, so it is applied directly.
          state_d = IDLE;
          cnt_d   = '0;
          if (xfer) begin
            if (sq_bad) begin
              err_d = 1'b1;
            end else begin
              cur_sq_d = cfg_sq;
              done_d   = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_next;
          if (xfer) begin
            if (sq_bad) begin
              err_d = 1'b1;
            end else if (term) begin
              cur_sq_d = cfg_sq;
              done_d   = 1'b1;
            end else begin
              pend_sq_d = cfg_sq;
              state_d   = PEND;
            end
          end
        end
      end

      PEND: begin
        if (!enable) begin
          state_d  = IDLE;
          cnt_d    = '0;
          cur_sq_d = pend_sq_q;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_next;
          if (term) begin
            cur_sq_d = pend_sq_q;
            state_d  = RUN;
            done_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_sq_q  <= SQ_W'(RST_SQ);
      pend_sq_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sq_q  <= cur_sq_d;
      pend_sq_q <= pend_sq_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef DIV_SCHED_PERIOD_CNT_EN
  logic [15:0] period_cnt_q;

  // An exponent change restarts the count even if the same edge ends a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_q <= '0;
    end else if (cur_sq_d != cur_sq_q) begin
      period_cnt_q <= '0;
    end else if (clk_en && (period_cnt_q != 16'hFFFF)) begin
      period_cnt_q <= period_cnt_q + 16'd1;
    end
  end

  assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_div_sched_ctrl.sv
module tb_div_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       cfg_valid;
  logic [3:0] cfg_sq;
  logic       cfg_ready;
  logic       cfg_done;
  logic       cfg_err;
  logic [3:0] cur_sq;
  logic       clk_en;
  logic       div_phase;
  logic       busy;
`ifdef DIV_SCHED_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  div_sched_ctrl #(
    .MAX_SQ(8),
    .SQ_W  (4),
    .RST_SQ(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_sq   (cfg_sq),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .cur_sq   (cur_sq),
    .clk_en   (clk_en),
    .div_phase(div_phase),
`ifdef DIV_SCHED_PERIOD_CNT_EN
    .period_cnt(period_cnt),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       clk_en;
    logic       phase;
    logic       ready;
    logic       done;
    logic       err;
    logic       busy;
    logic [3:0] sq;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    c        = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs for a cycle, derived from the period position.
  function automatic exp_t mk(input bit run, input int sq, input int cnt,
                              input bit ready, input bit done, input bit err);
    exp_t e;
    int   p;
    p        = 1 << sq;
    e.clk_en = run && (cnt == p - 1);
    e.phase  = run && (sq > 0) && (cnt >= p / 2);
    e.ready  = ready;
    e.done   = done;
    e.err    = err;
    e.busy   = run;
    e.sq     = 4'(sq);
    return e;
  endfunction

  // Drive inputs for the next edge and queue what the DUT should show after it.
  task automatic step(input bit en, input bit v, input int sq,
                      input bit run, input int esq, input int cnt,
                      input bit ready, input bit done, input bit err, input string tag);
    @(negedge clk);
    enable    = en;
    cfg_valid = v;
    cfg_sq    = 4'(sq);
    exp_q.push_back(mk(run, esq, cnt, ready, done, err));
    tag_q.push_back(tag);
  endtask

  task automatic run_n(input int n, input int esq, input string tag);
    for (int k = 0; k < n; k++) begin
      c = (c + 1) % (1 << esq);
      step(1'b1, 1'b0, 0, 1'b1, esq, c, 1'b1, 1'b0, 1'b0, tag);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, "_clk_en"}, 16'(clk_en),    16'(e.clk_en));
      chk({t, "_phase"},  16'(div_phase), 16'(e.phase));
      chk({t, "_ready"},  16'(cfg_ready), 16'(e.ready));
      chk({t, "_done"},   16'(cfg_done),  16'(e.done));
      chk({t, "_err"},    16'(cfg_err),   16'(e.err));
      chk({t, "_busy"},   16'(busy),      16'(e.busy));
      chk({t, "_cur_sq"}, 16'(cur_sq),    16'(e.sq));
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_cur_sq"}, 16'(cur_sq),    16'd1);
    chk({tag, "_ready"},  16'(cfg_ready), 16'd1);
    chk({tag, "_busy"},   16'(busy),      16'd0);
    chk({tag, "_clk_en"}, 16'(clk_en),    16'd0);
    chk({tag, "_phase"},  16'(div_phase), 16'd0);
    chk({tag, "_done"},   16'(cfg_done),  16'd0);
    chk({tag, "_err"},    16'(cfg_err),   16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_sq    = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst = 1'b0;

    // Reset exponent 1: clk_en every 2nd cycle, phase toggles each cycle
    step(1, 0, 0, 1, 1, 0, 1, 0, 0, "s1_start");
    c = 0;
    run_n(7, 1, "s1_run");
    step(0, 0, 0, 0, 1, 0, 1, 0, 0, "s1_stop");

    // IDLE accept of exponent 3, then an 8-cycle cadence
    step(0, 1, 3, 0, 3, 0, 1, 1, 0, "s2_acc");
    step(1, 0, 0, 1, 3, 0, 1, 0, 0, "s2_start");
    c = 0;
    run_n(15, 3, "s2_run");

    // Request exponent 2 at cnt=2: pending until the period boundary
    run_n(3, 3, "s3_pre");
    step(1, 1, 2, 1, 3, 3, 0, 0, 0, "s3_xfer");
    step(1, 0, 0, 1, 3, 4, 0, 0, 0, "s3_pend");
    step(1, 1, 6, 1, 3, 5, 0, 0, 0, "s3_pend_ign");
    step(1, 0, 0, 1, 3, 6, 0, 0, 0, "s3_pend");
    step(1, 0, 0, 1, 3, 7, 0, 0, 0, "s3_term");
    step(1, 0, 0, 1, 2, 0, 1, 1, 0, "s3_switch");
    c = 0;
    run_n(8, 2, "s3_run");

    // Request exponent 4 exactly on the terminal cycle: immediate switch
    run_n(3, 2, "s4_pre");
    step(1, 1, 4, 1, 4, 0, 1, 1, 0, "s4_xfer");
    c = 0;
    run_n(15, 4, "s4_run");

    // Out-of-range exponent rejected without disturbing the cadence
    run_n(2, 4, "s5_pre");
    step(1, 1, 9, 1, 4, 2, 1, 0, 1, "s5_err");
    c = 2;
    run_n(14, 4, "s5_run");

    // Enable dropped at cnt=5 of an 8-cycle period
    step(0, 0, 0, 0, 4, 0, 1, 0, 0, "s6_stop");
    step(0, 1, 3, 0, 3, 0, 1, 1, 0, "s6_acc");
    step(1, 0, 0, 1, 3, 0, 1, 0, 0, "s6_start");
    c = 0;
    run_n(5, 3, "s6_run");
    step(0, 0, 0, 0, 3, 0, 1, 0, 0, "s6_abort");
    step(0, 0, 0, 0, 3, 0, 1, 0, 0, "s6_idle");

    // Enable dropped while a change is pending
    step(1, 0, 0, 1, 3, 0, 1, 0, 0, "s7_start");
    step(1, 1, 5, 1, 3, 1, 0, 0, 0, "s7_xfer");
    step(1, 0, 0, 1, 3, 2, 0, 0, 0, "s7_pend");
    step(0, 0, 0, 0, 5, 0, 1, 1, 0, "s7_abort");
    step(0, 0, 0, 0, 5, 0, 1, 0, 0, "s7_idle");

    // Asynchronous reset in the middle of PEND
    step(1, 0, 0, 1, 5, 0, 1, 0, 0, "s8_start");
    step(1, 1, 2, 1, 5, 1, 0, 0, 0, "s8_xfer");
    step(1, 0, 0, 1, 5, 2, 0, 0, 0, "s8_pend");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset("s8_rst");
    @(negedge clk);
    rst       = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;

    // Exponent limits: MAX_SQ accepted, 0 gives clk_en every cycle
    step(0, 1, 8, 0, 8, 0, 1, 1, 0, "s9_max");
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, "s9_zero");
    step(1, 0, 0, 1, 0, 0, 1, 0, 0, "s9_start");
    c = 0;
    run_n(3, 0, "s9_run");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, "s9_stop");
    step(0, 1, 15, 0, 0, 0, 1, 0, 1, "s9_err_idle");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, "s9_idle");

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) chk("drain", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
